alu_exec_unit: RTL

- Parametrised, handshaked ALU execute stage. Successor to the combinational 4-bit ALU control decode.
- Decodes alu_ctr internally, registers the result, and supports XLEN-wide operands.
- Shifts run either as a single-cycle barrel shift or iteratively, one bit per cycle, chosen by parameter.
- Sits between the operand-read and writeback stages of the multi-cycle core variant, with valid/ready on both sides.

---
 rtl/alu_exec_unit_if.sv | 27 ++
 rtl/alu_exec_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit_if.sv
// Handshake and operand/result bundle between operand-read, the ALU execute
// stage and writeback. master = the surrounding pipeline, slave = the ALU.
interface alu_exec_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_ctr;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;

    modport master (
        output in_valid, alu_ctr, a, b, flush, out_ready,
        input  in_ready, out_valid, result, zero, illegal
    );

    modport slave (
        input  in_valid, alu_ctr, a, b, flush, out_ready,
        output in_ready, out_valid, result, zero, illegal
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Handshaked ALU execute stage: decodes alu_ctr, registers the result and
// zero flag, and performs shifts either in one cycle or one bit per cycle.
module alu_exec_unit #(
    parameter int XLEN       = 32,
    parameter int SHIFT_ITER = 0,
    parameter int SHAMT_W    = $clog2(XLEN)
) (
    input  logic           clk,
    input  logic           rst,
    alu_exec_unit_if.slave bus
);

    localparam bit ITER = (SHIFT_ITER != 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 w_in_ready;
    logic                 w_out_valid;
    logic                 w_accept;
    logic                 w_legal;
    logic                 w_iter;
    logic [SHAMT_W-1:0]   w_shamt;
    logic [XLEN-1:0]      w_alu;
    logic [XLEN-1:0]      w_step;
    logic [XLEN-1:0]      r_work;
    logic [3:0]           r_op;
    logic [SHAMT_W-1:0]   r_cnt;
    logic [XLEN-1:0]      r_result;
    logic                 r_zero;
    logic                 r_illegal;

    function automatic logic f_legal(input logic [3:0] ctr);
        case (ctr)
            4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
            4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111: f_legal = 1'b1;
            default:                                     f_legal = 1'b0;
        endcase
    endfunction

    function automatic logic f_is_shift(input logic [3:0] ctr);
        f_is_shift = (ctr == 4'b0001) || (ctr == 4'b0101) || (ctr == 4'b1101);
    endfunction

    // Full single-cycle result; illegal codes yield zero.
    function automatic logic [XLEN-1:0] f_alu(input logic [3:0]      ctr,
                                              input logic [XLEN-1:0] op_a,
                                              input logic [XLEN-1:0] op_b);
        logic signed [XLEN-1:0] sa;
        logic signed [XLEN-1:0] sb;
        logic [SHAMT_W-1:0]     sh;
        sa = op_a;
        sb = op_b;
        sh = op_b[SHAMT_W-1:0];
        case (ctr)
            4'b0000: f_alu = op_a + op_b;
            4'b1000: f_alu = op_a - op_b;
            4'b0001: f_alu = op_a << sh;
            4'b0010: f_alu = {{(XLEN-1){1'b0}}, (sa < sb)};
            4'b0011: f_alu = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            4'b0100: f_alu = op_a ^ op_b;
            4'b0101: f_alu = op_a >> sh;
            4'b1101: f_alu = sa >>> sh;
            4'b0110: f_alu = op_a | op_b;
            4'b0111: f_alu = op_a & op_b;
            default: f_alu = '0;
        endcase
    endfunction

    // One-bit step of the iterative shifter; sra replicates the sign bit.
    function automatic logic [XLEN-1:0] f_step(input logic [3:0]      op,
                                               input logic [XLEN-1:0] v);
        case (op)
            4'b0001: f_step = {v[XLEN-2:0], 1'b0};
            4'b0101: f_step = {1'b0, v[XLEN-1:1]};
            default: f_step = {v[XLEN-1], v[XLEN-1:1]};
        endcase
    endfunction

    assign w_shamt  = bus.b[SHAMT_W-1:0];
    assign w_legal  = f_legal(bus.alu_ctr);
    assign w_iter   = ITER && f_is_shift(bus.alu_ctr) && (w_shamt != '0);
    assign w_alu    = f_alu(bus.alu_ctr, bus.a, bus.b);
    assign w_step   = f_step(r_op, r_work);
    // flush wins over a same-cycle offer, so it blocks the accept
    assign w_accept = bus.in_valid & w_in_ready & ~bus.flush;

    // State register; reset discards any in-flight shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; flush returns to IDLE from any state.
    always_comb begin
        w_next = r_state;
        if (bus.flush) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) w_next = w_iter ? ST_SHIFT : ST_DONE;
                end
                ST_SHIFT: begin
                    if (r_cnt == SHAMT_W'(1)) w_next = ST_DONE;
                end
                ST_DONE: begin
                    if (w_accept)          w_next = w_iter ? ST_SHIFT : ST_DONE;
                    else if (bus.out_ready) w_next = ST_IDLE;
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    // Handshake outputs; DONE can accept when the held result is being taken.
    always_comb begin
        w_in_ready  = (r_state == ST_IDLE) | ((r_state == ST_DONE) & bus.out_ready);
        w_out_valid = (r_state == ST_DONE);
    end

    // Result, flags and shift counter; result stays put while not retired.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
            r_cnt     <= '0;
        end else if (bus.flush) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            if (w_iter) begin
                r_cnt <= w_shamt;
            end else begin
                r_result  <= w_alu;
                r_zero    <= (w_alu == '0);
                r_illegal <= ~w_legal;
            end
        end else if (r_state == ST_SHIFT) begin
            r_cnt <= r_cnt - SHAMT_W'(1);
            if (r_cnt == SHAMT_W'(1)) begin
                r_result  <= w_step;
                r_zero    <= (w_step == '0);
                r_illegal <= 1'b0;
            end
        end
    end

    // Iterative-shift work register and opcode; contents only matter in SHIFT.
    always_ff @(posedge clk) begin
        if (w_accept && w_iter) begin
            r_work <= bus.a;
            r_op   <= bus.alu_ctr;
        end else if (r_state == ST_SHIFT) begin
            r_work <= w_step;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.illegal   = r_illegal;

endmodule
